// File: rtl/conv_writeback_param_3_if.sv
// Write-back bus between the layer-3 accumulator array and the output-feature memories.
// The master side is the write-back controller; the slave side is the surrounding datapath.
interface conv_writeback_param_3_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int NUM_DSP    = 4,
   parameter int ADDR_WIDTH = 10
);
   logic                            enable;
   logic                            accum_sload;
   logic [ACC_WIDTH*NUM_DSP-1:0]    accum_result;
   logic                            out_feature_wren;
   logic [ADDR_WIDTH-1:0]           out_feature_address;
   logic [DATA_WIDTH*NUM_DSP-1:0]   out_feature_data_all;
   logic                            write_done;
   logic                            sat_flag;

   modport master (
      input  enable, accum_sload, accum_result,
      output out_feature_wren, out_feature_address, out_feature_data_all,
             write_done, sat_flag
   );

   modport slave (
      output enable, accum_sload, accum_result,
      input  out_feature_wren, out_feature_address, out_feature_data_all,
             write_done, sat_flag
   );
endinterface

// File: rtl/conv_writeback_param_3.sv
// Layer-3 write-back: captures finished accumulator sums a fixed latency after each
// reload strobe, requantizes every lane and writes them to the output maps in order.
module conv_writeback_param_3 #(
   parameter int DATA_WIDTH        = 16,
   parameter int ACC_WIDTH         = 32,
   parameter int NUM_DSP           = 4,
   parameter int OUT_FEATURE_WIDTH = 5,
   parameter int NUM_ONEMULT       = 4,
   parameter int FRAC_BITS         = 8,
   parameter int RELU              = 1,
   parameter int RESULT_LATENCY    = 2,
   parameter int ADDR_WIDTH        = 10
) (
   input  logic                      clock,
   input  logic                      reset,
   conv_writeback_param_3_if.master  wb
);

   localparam int TOTAL = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SKIP = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [ADDR_WIDTH:0]   TOTAL_X   = (ADDR_WIDTH+1)'(TOTAL);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);

   localparam logic signed [ACC_WIDTH-1:0] MAX_S =
      $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_WIDTH-1:0] MIN_S =
      $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

   // Returns {saturated, word}; ReLU takes priority so negative sums never flag.
   function automatic logic [DATA_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
      logic signed [ACC_WIDTH-1:0] s;
      s = acc >>> FRAC_BITS;
      if ((RELU != 0) && s[ACC_WIDTH-1])
         requant = '0;
      else if (s > MAX_S)
         requant = {1'b1, MAX_S[DATA_WIDTH-1:0]};
      else if (s < MIN_S)
         requant = {1'b1, MIN_S[DATA_WIDTH-1:0]};
      else
         requant = {1'b0, DATA_WIDTH'(s)};
   endfunction

   logic [1:0]                      state;
   logic [RESULT_LATENCY-1:0]       vld_p;
   logic                            accept;
   logic                            capture;
   logic [DATA_WIDTH*NUM_DSP-1:0]   q_data_p0;
   logic                            q_sat_p0;
   logic                            wren_p1;
   logic [ADDR_WIDTH-1:0]           addr_p1;
   logic [DATA_WIDTH*NUM_DSP-1:0]   data_p1;
   logic                            done_r;
   logic                            sat_r;

   assign accept = wb.enable && wb.accum_sload && (state == RUN);

   // A capture is only allowed while writes remain; the one in flight on wren_p1 counts.
   assign capture = vld_p[RESULT_LATENCY-1] && (state == RUN) &&
                    (({1'b0, addr_p1} + (ADDR_WIDTH+1)'(wren_p1)) < TOTAL_X);

   // Stage p0: requantize all lanes from the live accumulator bus
   always_comb begin
      logic [DATA_WIDTH:0] lane_q;
      lane_q    = '0;
      q_data_p0 = '0;
      q_sat_p0  = 1'b0;
      for (int k = 0; k < NUM_DSP; k++) begin
         lane_q = requant($signed(wb.accum_result[k*ACC_WIDTH +: ACC_WIDTH]));
         q_data_p0[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[DATA_WIDTH-1:0];
         q_sat_p0 = q_sat_p0 | lane_q[DATA_WIDTH];
      end
   end

   // Stage p1: registered write port, address counter and run-control FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         vld_p   <= '0;
         wren_p1 <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         done_r  <= 1'b0;
         sat_r   <= 1'b0;
      end else begin
         vld_p   <= (vld_p << 1) | RESULT_LATENCY'(accept);
         wren_p1 <= capture;
         if (capture) begin
            data_p1 <= q_data_p0;
            if (q_sat_p0)
               sat_r <= 1'b1;
         end
         if (wren_p1)
            addr_p1 <= addr_p1 + 1'b1;
         case (state)
            IDLE: if (wb.enable) state <= SKIP;
            // The first reload after enable flushes an empty accumulator.
            SKIP: if (wb.enable && wb.accum_sload) state <= RUN;
            RUN: begin
               if (wren_p1 && (addr_p1 == LAST_ADDR)) begin
                  state  <= DONE;
                  done_r <= 1'b1;
               end
            end
            default: state <= DONE;
         endcase
      end
   end

   assign wb.out_feature_wren     = wren_p1;
   assign wb.out_feature_address  = addr_p1;
   assign wb.out_feature_data_all = data_p1;
   assign wb.write_done           = done_r;
   assign wb.sat_flag             = sat_r;

endmodule

// File: tb/tb_conv_writeback_param_3.sv
// Scoreboard bench for conv_writeback_param_3: directed pulse trains push expected writes,
// a negedge monitor pops and compares address, data and arrival cycle.
module tb_conv_writeback_param_3;
   localparam int DW    = 16;
   localparam int AW    = 32;
   localparam int ND    = 4;
   localparam int ADW   = 10;
   localparam int TOTAL = 100;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   conv_writeback_param_3_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_DSP(ND), .ADDR_WIDTH(ADW)) wb();

   conv_writeback_param_3 dut (
      .clock (clock),
      .reset (reset),
      .wb    (wb)
   );

   typedef struct packed {
      logic [ADW-1:0]   addr;
      logic [DW*ND-1:0] data;
      logic [31:0]      cyc;
   } exp_t;

   exp_t             exp_q[$];
   logic [AW*ND-1:0] vals[$];
   logic [DW*ND-1:0] exps[$];
   int               errors = 0;
   int               checks = 0;
   int               exp_addr = 0;
   logic [31:0]      cyc = 0;
   bit               done_chk = 0;

   always @(posedge clock) cyc <= cyc + 32'd1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle(2);
   endtask

   task automatic add(input logic [AW*ND-1:0] v, input logic [DW*ND-1:0] e);
      vals.push_back(v);
      exps.push_back(e);
   endtask

   // Pulse i goes out at relative cycle i*gap; its sums are on the bus two cycles later.
   // With reset_at >= 0, reset is driven in that cycle and the train stops.
   task automatic burst(input int gap, input bit expect_wr, input int reset_at);
      int n;
      int last;
      n    = vals.size();
      last = (n - 1) * gap + 2;
      for (int c = 0; c <= last; c++) begin
         if (c == reset_at) begin
            reset = 1'b1;
            wb.accum_sload = 1'b0;
            wb.accum_result = '0;
            tick();
            reset = 1'b0;
            break;
         end
         wb.accum_sload = ((c % gap) == 0) && ((c / gap) < n);
         if (wb.accum_sload && expect_wr && (exp_addr < TOTAL) &&
             ((reset_at < 0) || (c + 3 <= reset_at))) begin
            exp_q.push_back('{addr: ADW'(exp_addr), data: exps[c / gap], cyc: cyc + 32'd3});
            exp_addr++;
         end
         if ((c >= 2) && (((c - 2) % gap) == 0) && (((c - 2) / gap) < n))
            wb.accum_result = vals[(c - 2) / gap];
         else
            wb.accum_result = '0;
         tick();
      end
      wb.accum_sload  = 1'b0;
      wb.accum_result = '0;
      vals.delete();
      exps.delete();
   endtask

   task automatic skip_pulse();
      add('0, '0);
      burst(4, 1'b0, -1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (done_chk) begin
            chk("write_done_rise", 64'(wb.write_done), 64'd1);
            done_chk = 0;
         end
         if (wb.out_feature_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0d data=%h required no write",
                        wb.out_feature_address, wb.out_feature_data_all);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(wb.out_feature_address), 64'(e.addr));
               chk("wr_data", 64'(wb.out_feature_data_all), 64'(e.data));
               chk("wr_cycle", 64'(cyc), 64'(e.cyc));
               chk("done_before_last", 64'(wb.write_done), 64'd0);
               if (e.addr == ADW'(TOTAL - 1)) done_chk = 1;
            end
         end
      end
   end

   initial begin : stimulus
      logic [AW*ND-1:0] v;
      logic [DW*ND-1:0] e;

      // Reset held two cycles with the strobe toggling
      reset = 1'b1;
      wb.enable = 1'b1;
      wb.accum_sload = 1'b1;
      wb.accum_result = {ND{32'h00FF0000}};
      tick();
      wb.accum_sload = 1'b0;
      tick();
      chk("rst_wren", 64'(wb.out_feature_wren), 64'd0);
      chk("rst_addr", 64'(wb.out_feature_address), 64'd0);
      chk("rst_data", 64'(wb.out_feature_data_all), 64'd0);
      chk("rst_done", 64'(wb.write_done), 64'd0);
      chk("rst_sat", 64'(wb.sat_flag), 64'd0);
      reset = 1'b0;
      wb.enable = 1'b0;
      wb.accum_result = '0;
      idle(2);

      // Pulse while disabled in IDLE must not act as the skip pulse
      add({ND{32'h00001000}}, {ND{16'h0010}});
      burst(4, 1'b0, -1);
      wb.enable = 1'b1;
      idle(2);

      skip_pulse();
      add({96'h0, 32'h00001280}, {48'h0, 16'h0012});
      burst(4, 1'b1, -1);
      idle(3);

      // Requantization edges
      add({32'hFFFFFF00, 32'h00000100, 32'h00007FFF, 32'hFFFFF000},
          {16'h0000, 16'h0001, 16'h007F, 16'h0000});
      burst(5, 1'b1, -1);
      add({32'h00000000, 32'h00000000, 32'h007FFF00, 32'hFFFFFFFF},
          {16'h0000, 16'h0000, 16'h7FFF, 16'h0000});
      burst(5, 1'b1, -1);
      idle(2);
      chk("sat_clear_at_max", 64'(wb.sat_flag), 64'd0);
      add({ND{32'h00FF0000}}, {ND{16'h7FFF}});
      burst(5, 1'b1, -1);
      idle(2);
      chk("sat_set", 64'(wb.sat_flag), 64'd1);
      add({32'h7FFFFFFF, 32'h80000000, 32'h00800000, 32'h00000080},
          {16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000});
      burst(5, 1'b1, -1);
      idle(3);

      // Pulses with enable low mid-run are ignored; the address resumes afterwards
      wb.enable = 1'b0;
      add({ND{32'h00000500}}, {ND{16'h0005}});
      add({ND{32'h00000600}}, {ND{16'h0006}});
      add({ND{32'h00000700}}, {ND{16'h0007}});
      burst(3, 1'b0, -1);
      wb.enable = 1'b1;
      add({ND{32'h00002A00}}, {ND{16'h002A}});
      burst(4, 1'b1, -1);
      idle(3);
      chk("addr_after_resume", 64'(wb.out_feature_address), 64'd6);

      // Full run: skip + 100 writes, then one extra pulse
      do_reset();
      exp_addr = 0;
      chk("sat_cleared_by_reset", 64'(wb.sat_flag), 64'd0);
      skip_pulse();
      for (int i = 0; i < TOTAL; i++) begin
         for (int k = 0; k < ND; k++) begin
            v[k*AW +: AW] = 32'((i * 4 + k) << 8);
            e[k*DW +: DW] = 16'(i * 4 + k);
         end
         add(v, e);
      end
      burst(25, 1'b1, -1);
      idle(4);
      add({ND{32'h00001100}}, {ND{16'h0011}});
      burst(25, 1'b1, -1);
      idle(4);
      chk("addr_stops_at_total", 64'(wb.out_feature_address), 64'(TOTAL));
      chk("done_sticky", 64'(wb.write_done), 64'd1);

      // Back-to-back pulses
      do_reset();
      exp_addr = 0;
      chk("done_cleared", 64'(wb.write_done), 64'd0);
      skip_pulse();
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < ND; k++) begin
            v[k*AW +: AW] = 32'(((i * 4 + k + 1) << 8) | 8'hC0);
            e[k*DW +: DW] = 16'(i * 4 + k + 1);
         end
         add(v, e);
      end
      burst(1, 1'b1, -1);
      idle(4);
      chk("b2b_addr", 64'(wb.out_feature_address), 64'd8);

      // Reset during the write to address 50 cancels the capture behind it
      do_reset();
      exp_addr = 0;
      skip_pulse();
      for (int i = 0; i < 60; i++) begin
         for (int k = 0; k < ND; k++) begin
            v[k*AW +: AW] = 32'((i + k) << 8);
            e[k*DW +: DW] = 16'(i + k);
         end
         add(v, e);
      end
      burst(2, 1'b1, 103);
      chk("midrst_wren", 64'(wb.out_feature_wren), 64'd0);
      chk("midrst_addr", 64'(wb.out_feature_address), 64'd0);
      idle(2);
      exp_addr = 0;
      skip_pulse();
      add({ND{32'h00003300}}, {ND{16'h0033}});
      add({ND{32'h00004400}}, {ND{16'h0044}});
      burst(4, 1'b1, -1);
      idle(5);
      chk("restart_addr", 64'(wb.out_feature_address), 64'd2);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
